// File: rtl/char_shifter_pkg.sv
// rtl/char_shifter_pkg.sv - shared display constants: cell width, attribute fields, sync polarity
package char_shifter_pkg;

  localparam int CHAR_WIDTH_DEF = 8;

  // Attribute byte layout: {blink, bg[2:0], inverse, fg[2:0]}
  localparam int ATT_BLINK_BIT = 7;
  localparam int ATT_BG_HI     = 6;
  localparam int ATT_BG_LO     = 4;
  localparam int ATT_INV_BIT   = 3;
  localparam int ATT_FG_HI     = 2;
  localparam int ATT_FG_LO     = 0;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;
  localparam logic BLANK_RST   = 1'b0;

  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_shifter_sync_delay.sv
// rtl/char_shifter_sync_delay.sv - enabled shift chain of configurable depth, width and reset value
module sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/char_shifter.sv
// rtl/char_shifter.sv - font-row serialiser with attribute latch, sync delay and frame blink
module char_shifter
  import char_shifter_pkg::*;
#(
  parameter int CHAR_WIDTH   = CHAR_WIDTH_DEF,
  parameter int SYNC_DELAY   = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixclk,
  input  logic                  load,
  input  logic [CHAR_WIDTH-1:0] font_row,
  input  logic [7:0]            attcode_in,
  input  logic                  blank_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic                  pixel,
  output logic [7:0]            attcode,
  output logic                  blank,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blink
);

  localparam int              CW      = ctr_width(BLINK_FRAMES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(BLINK_FRAMES - 1);

  logic [CHAR_WIDTH-1:0] r_shreg;
  logic [7:0]            r_att;
  logic                  r_vs_prev;
  logic [CW-1:0]         r_frame_cnt;
  logic                  r_blink;
  logic                  w_frame_evt;
  logic [2:0]            w_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_att   <= 8'h00;
    end else if (pixclk) begin
      if (load) begin
        r_shreg <= font_row;
        r_att   <= attcode_in;
      end else begin
        r_shreg <= {r_shreg[CHAR_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Frame boundary is the falling edge of vsync_in as seen on pixel ticks.
  assign w_frame_evt = r_vs_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev   <= SYNC_IDLE;
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (pixclk) begin
      r_vs_prev <= vsync_in;
      if (w_frame_evt) begin
        if (r_frame_cnt == CNT_MAX) begin
          r_frame_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  sync_delay #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   (3),
    .RST_VAL ({BLANK_RST, SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .i_en (pixclk),
    .i_d  ({blank_in, hsync_in, vsync_in}),
    .o_q  (w_sync_q)
  );

  assign pixel   = r_shreg[CHAR_WIDTH-1];
  assign attcode = r_att;
  assign blank   = w_sync_q[2];
  assign hsync   = w_sync_q[1];
  assign vsync   = w_sync_q[0];
  assign blink   = r_blink;

endmodule
